ref_fifo_rd_streamer: RTL and testbench

//  Downstream read-side consumer of the dual-clock data FIFO (rd_clk domain, latency-1 mode). Pops

---
 rtl/ref_fifo_rd_streamer.sv | 137 +++++++++++++
 tb/tb_ref_fifo_rd_streamer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ref_fifo_rd_streamer.sv
// Read-side consumer of the dual-clock data FIFO: pops words and presents them as a framed valid/ready stream.
// Optional per-packet/error statistics counters are enabled by defining REF_FIFO_RD_STREAMER_STATS_EN.
module ref_fifo_rd_streamer #(
  parameter int DATA_WIDTH    = 72,
  parameter int LEN_WIDTH     = 10,
  parameter int MAX_PKT_WORDS = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  output logic                  fifo_rd_ack,
  input  logic                  fifo_rd_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-2:0] m_data,
  output logic                  m_sop,
  output logic                  m_eop,
  output logic                  len_err,
`ifdef REF_FIFO_RD_STREAMER_STATS_EN
  output logic [31:0]           pkt_count,
  output logic [15:0]           err_count,
`endif
  output logic                  busy
);

  localparam int PW = DATA_WIDTH - 1;
  localparam logic [LEN_WIDTH-1:0] LAST_WORD = LEN_WIDTH'(MAX_PKT_WORDS - 1);

  typedef struct packed {
    logic [PW-1:0] payload;
    logic          sop;
    logic          eop;
  } entry_t;

  entry_t               head_q;
  entry_t               tail_q;
  entry_t               cap_entry;
  logic [1:0]           occ;
  logic                 inflight;
  logic [LEN_WIDTH-1:0] word_cnt;
  logic                 sop_pend;
  logic [2:0]           fill;
  logic                 pop;
  logic                 forced_eop;

  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    fill              = {1'b0, occ} + {2'b00, inflight};
    pop               = m_valid & m_ready;
    forced_eop        = (word_cnt == LAST_WORD);
    cap_entry.payload = fifo_rd_data[PW-1:0];
    cap_entry.sop     = sop_pend;
    cap_entry.eop     = fifo_rd_data[DATA_WIDTH-1] | forced_eop;
    // A pop is only safe if the word landing next cycle is guaranteed a free buffer slot.
    fifo_rd_ack       = ~fifo_rd_empty & ~clr &
                        ((fill <= 3'd1) | ((fill == 3'd2) & pop));
  end

  assign m_valid = (occ != 2'd0);
  assign m_data  = head_q.payload;
  assign m_sop   = m_valid & head_q.sop;
  assign m_eop   = m_valid & head_q.eop;
  assign busy    = m_valid | inflight;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  // NOTE: the two buffer entries are reset because m_data must read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      occ      <= 2'd0;
      inflight <= 1'b0;
      word_cnt <= '0;
      sop_pend <= 1'b1;
      len_err  <= 1'b0;
    end else if (clr) begin
      // The in-flight word is dropped; upstream clears its FIFO in the same cycle.
      head_q   <= '0;
      tail_q   <= '0;
      occ      <= 2'd0;
      inflight <= 1'b0;
      word_cnt <= '0;
      sop_pend <= 1'b1;
      len_err  <= 1'b0;
    end else begin
      inflight <= fifo_rd_ack;
      len_err  <= inflight & forced_eop & ~fifo_rd_data[DATA_WIDTH-1];
      if (inflight) begin
        if (cap_entry.eop) begin
          word_cnt <= '0;
          sop_pend <= 1'b1;
        end else begin
          word_cnt <= word_cnt + 1'b1;
          sop_pend <= 1'b0;
        end
      end
      case ({pop, inflight})
        2'b11: begin
          if (occ == 2'd2) begin
            head_q <= tail_q;
            tail_q <= cap_entry;
          end else begin
            head_q <= cap_entry;
          end
        end
        2'b10: begin
          head_q <= tail_q;
          occ    <= occ - 2'd1;
        end
        2'b01: begin
          if (occ == 2'd0) head_q <= cap_entry;
          else             tail_q <= cap_entry;
          occ <= occ + 2'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef REF_FIFO_RD_STREAMER_STATS_EN
  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count <= '0;
      err_count <= '0;
    end else if (clr) begin
      pkt_count <= '0;
      err_count <= '0;
    end else begin
      if (pop && m_eop && (pkt_count != '1)) pkt_count <= pkt_count + 32'd1;
      if (len_err && (err_count != '1))      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ref_fifo_rd_streamer.sv
// Directed bench for ref_fifo_rd_streamer: FIFO read-port model, per-scenario tasks, one summary line.
module tb_ref_fifo_rd_streamer;

  localparam int DW  = 16;
  localparam int PW  = DW - 1;
  localparam int MAX = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic          fifo_rd_ack;
  logic          fifo_rd_empty;
  logic [DW-1:0] fifo_rd_data;
  logic          m_valid;
  logic          m_ready;
  logic [PW-1:0] m_data;
  logic          m_sop;
  logic          m_eop;
  logic          len_err;
  logic          busy;
`ifdef REF_FIFO_RD_STREAMER_STATS_EN
  logic [31:0]   pkt_count;
  logic [15:0]   err_count;
`endif

  ref_fifo_rd_streamer #(.DATA_WIDTH(DW), .LEN_WIDTH(10), .MAX_PKT_WORDS(MAX)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .fifo_rd_ack(fifo_rd_ack), .fifo_rd_empty(fifo_rd_empty), .fifo_rd_data(fifo_rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sop(m_sop), .m_eop(m_eop),
    .len_err(len_err),
`ifdef REF_FIFO_RD_STREAMER_STATS_EN
    .pkt_count(pkt_count), .err_count(err_count),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fifo_q [$];
  logic [PW+1:0] out_q  [$];
  int checks = 0;
  int errors = 0;
  int ack_cnt, lerr_cnt, ack_empty, max_occ;
  logic s_ack, s_valid, s_sop, s_eop, s_busy, s_acc;
  logic [PW-1:0] s_data, lerr_data;

  // FIFO read port in latency-1 mode: data appears the cycle after an accepted pop.
  always @(posedge clk) begin
    if (fifo_rd_ack && fifo_q.size() != 0) fifo_rd_data <= fifo_q.pop_front();
  end

  // One clock cycle: inputs were set at the preceding negedge; sample 1 ns later, then wait.
  task automatic cycle();
    fifo_rd_empty = (fifo_q.size() == 0);
    #1;
    s_ack = fifo_rd_ack; s_valid = m_valid; s_sop = m_sop; s_eop = m_eop;
    s_busy = busy; s_data = m_data; s_acc = m_valid && m_ready;
    if (fifo_rd_ack && fifo_rd_empty) ack_empty++;
    if (fifo_rd_ack) ack_cnt++;
    if (len_err) begin lerr_cnt++; lerr_data = m_data; end
    if (int'(dut.occ) > max_occ) max_occ = int'(dut.occ);
    if (s_acc) out_q.push_back({m_data, m_sop, m_eop});
    @(negedge clk);
  endtask

  task automatic clear_stats();
    ack_cnt = 0; lerr_cnt = 0; ack_empty = 0; max_occ = 0;
    out_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cycle();
    checks++;
    if (s_ack !== 1'b0 || s_valid !== 1'b0 || s_busy !== 1'b0 || s_data !== '0) begin
      errors++;
      $display("FAIL reset_hold ack=%b valid=%b busy=%b data=%h expected 0/0/0/0", s_ack, s_valid, s_busy, s_data);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      checks++;
      if (s_ack !== 1'b0 || s_valid !== 1'b0 || s_busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d ack=%b valid=%b busy=%b expected 0/0/0", i, s_ack, s_valid, s_busy);
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] v_ack, v_val, v_sop, v_eop;
    logic [PW+1:0] exp_w [4];
    clear_stats();
    m_ready = 1'b1;
    fifo_q.push_back({1'b0, 15'h0101});
    fifo_q.push_back({1'b0, 15'h0102});
    fifo_q.push_back({1'b0, 15'h0103});
    fifo_q.push_back({1'b1, 15'h0104});
    exp_w[0] = {15'h0101, 1'b1, 1'b0};
    exp_w[1] = {15'h0102, 1'b0, 1'b0};
    exp_w[2] = {15'h0103, 1'b0, 1'b0};
    exp_w[3] = {15'h0104, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      cycle();
      v_ack[i] = s_ack; v_val[i] = s_valid; v_sop[i] = s_sop; v_eop[i] = s_eop;
    end
    checks++;
    if (v_ack !== 8'h0F) begin errors++; $display("FAIL basic_ack got %b expected %b", v_ack, 8'h0F); end
    checks++;
    if (v_val !== 8'h3C) begin errors++; $display("FAIL basic_valid got %b expected %b", v_val, 8'h3C); end
    checks++;
    if (v_sop !== 8'h04) begin errors++; $display("FAIL basic_sop got %b expected %b", v_sop, 8'h04); end
    checks++;
    if (v_eop !== 8'h20) begin errors++; $display("FAIL basic_eop got %b expected %b", v_eop, 8'h20); end
    checks++;
    if (out_q.size() != 4) begin
      errors++; $display("FAIL basic_count got %0d expected 4", out_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (out_q[i] !== exp_w[i]) begin
          errors++; $display("FAIL basic_word[%0d] got %h expected %h", i, out_q[i], exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [PW+1:0] exp_w [8];
    logic [7:0] flags;
    logic [PW-1:0] held;
    bit held_ok, seen;
    int first_acc, last_acc, cyc;
    clear_stats();
    m_ready = 1'b0;
    flags = 8'b1001_0100;  // EOP on words 3, 5 and 8
    for (int i = 0; i < 8; i++) begin
      fifo_q.push_back({flags[i], 15'(16'h0201 + i)});
    end
    exp_w[0] = {15'h0201, 1'b1, 1'b0};
    exp_w[1] = {15'h0202, 1'b0, 1'b0};
    exp_w[2] = {15'h0203, 1'b0, 1'b1};
    exp_w[3] = {15'h0204, 1'b1, 1'b0};
    exp_w[4] = {15'h0205, 1'b0, 1'b1};
    exp_w[5] = {15'h0206, 1'b1, 1'b0};
    exp_w[6] = {15'h0207, 1'b0, 1'b0};
    exp_w[7] = {15'h0208, 1'b0, 1'b1};
    held_ok = 1'b1; seen = 1'b0; held = '0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (s_valid) begin
        if (!seen) begin held = s_data; seen = 1'b1; end
        else if (s_data !== held) held_ok = 1'b0;
      end
    end
    checks++;
    if (ack_cnt != 2) begin errors++; $display("FAIL bp_acks got %0d expected 2", ack_cnt); end
    checks++;
    if (dut.occ !== 2'd2) begin errors++; $display("FAIL bp_occ got %0d expected 2", dut.occ); end
    checks++;
    if (!seen || held !== 15'h0201 || !held_ok) begin
      errors++; $display("FAIL bp_hold got %h stable=%0d expected 0201 stable=1", held, held_ok);
    end
    m_ready = 1'b1;
    first_acc = -1; last_acc = -1; cyc = 0;
    while (out_q.size() < 8 && cyc < 30) begin
      cycle();
      if (s_acc) begin
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
      cyc++;
    end
    checks++;
    if (first_acc != 0 || last_acc != 7) begin
      errors++; $display("FAIL bp_no_gap accepts in cycles %0d..%0d expected 0..7", first_acc, last_acc);
    end
    checks++;
    if (out_q.size() != 8) begin
      errors++; $display("FAIL bp_count got %0d expected 8", out_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (out_q[i] !== exp_w[i]) begin
          errors++; $display("FAIL bp_word[%0d] got %h expected %h", i, out_q[i], exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_len_guard();
    logic [PW+1:0] exp_w [7];
    int cyc;
    clear_stats();
    m_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      fifo_q.push_back({(i == 6), 15'(16'h0301 + i)});
    end
    exp_w[0] = {15'h0301, 1'b1, 1'b0};
    exp_w[1] = {15'h0302, 1'b0, 1'b0};
    exp_w[2] = {15'h0303, 1'b0, 1'b0};
    exp_w[3] = {15'h0304, 1'b0, 1'b1};
    exp_w[4] = {15'h0305, 1'b1, 1'b0};
    exp_w[5] = {15'h0306, 1'b0, 1'b0};
    exp_w[6] = {15'h0307, 1'b0, 1'b1};
    cyc = 0;
    while (out_q.size() < 7 && cyc < 40) begin cycle(); cyc++; end
    repeat (3) cycle();
    checks++;
    if (lerr_cnt != 1) begin errors++; $display("FAIL len_err_pulses got %0d expected 1", lerr_cnt); end
    checks++;
    if (lerr_data !== 15'h0304) begin
      errors++; $display("FAIL len_err_word got %h expected 0304", lerr_data);
    end
    checks++;
    if (out_q.size() != 7) begin
      errors++; $display("FAIL len_count got %0d expected 7", out_q.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (out_q[i] !== exp_w[i]) begin
          errors++; $display("FAIL len_word[%0d] got %h expected %h", i, out_q[i], exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] in_w [1000];
    logic [PW+1:0] exp_w [1000];
    int cnt, pushed, cyc, bad;
    bit sp, eop;
    clear_stats();
    cnt = 0; sp = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      in_w[i] = {($urandom_range(3) == 0), 15'($urandom)};
      eop = in_w[i][DW-1] || (cnt == MAX - 1);
      exp_w[i] = {in_w[i][PW-1:0], sp, eop};
      if (eop) begin cnt = 0; sp = 1'b1; end
      else begin cnt++; sp = 1'b0; end
    end
    pushed = 0; cyc = 0;
    while (out_q.size() < 1000 && cyc < 6000) begin
      if (pushed < 1000 && $urandom_range(1) == 1) begin
        fifo_q.push_back(in_w[pushed]);
        pushed++;
      end
      m_ready = ($urandom_range(1) == 1);
      cycle();
      cyc++;
    end
    m_ready = 1'b0;
    checks++;
    if (out_q.size() != 1000) begin
      errors++; $display("FAIL rand_count got %0d expected 1000", out_q.size());
    end
    bad = 0;
    for (int i = 0; i < out_q.size() && i < 1000; i++) begin
      checks++;
      if (out_q[i] !== exp_w[i]) begin
        errors++; bad++;
        if (bad <= 5) $display("FAIL rand_word[%0d] got %h expected %h", i, out_q[i], exp_w[i]);
      end
    end
    checks++;
    if (ack_cnt != 1000) begin errors++; $display("FAIL rand_acks got %0d expected 1000", ack_cnt); end
    checks++;
    if (ack_empty != 0) begin errors++; $display("FAIL rand_ack_empty got %0d expected 0", ack_empty); end
    checks++;
    if (max_occ > 2) begin errors++; $display("FAIL rand_occ max %0d expected <=2", max_occ); end
  endtask

  task automatic test_clr();
    logic [PW+1:0] exp_w [2];
    int cyc;
    clear_stats();
    m_ready = 1'b0;
    fifo_q.push_back({1'b0, 15'h0401});
    fifo_q.push_back({1'b0, 15'h0402});
    fifo_q.push_back({1'b1, 15'h0403});
    cycle();
    cycle();
    clr = 1'b1;
    fifo_q.delete();
    checks++;
    if (dut.occ !== 2'd1 || dut.inflight !== 1'b1) begin
      errors++; $display("FAIL clr_setup occ=%0d inflight=%b expected 1/1", dut.occ, dut.inflight);
    end
    cycle();
    checks++;
    if (s_ack !== 1'b0 || s_busy !== 1'b1) begin
      errors++; $display("FAIL clr_cycle ack=%b busy=%b expected 0/1", s_ack, s_busy);
    end
    clr = 1'b0;
    cycle();
    checks++;
    if (s_valid !== 1'b0 || s_busy !== 1'b0) begin
      errors++; $display("FAIL clr_after valid=%b busy=%b expected 0/0", s_valid, s_busy);
    end
    exp_w[0] = {15'h0405, 1'b1, 1'b0};
    exp_w[1] = {15'h0406, 1'b0, 1'b1};
    fifo_q.push_back({1'b0, 15'h0405});
    fifo_q.push_back({1'b1, 15'h0406});
    m_ready = 1'b1;
    cyc = 0;
    while (out_q.size() < 2 && cyc < 10) begin cycle(); cyc++; end
    checks++;
    if (out_q.size() != 2) begin
      errors++; $display("FAIL clr_count got %0d expected 2", out_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (out_q[i] !== exp_w[i]) begin
          errors++; $display("FAIL clr_word[%0d] got %h expected %h", i, out_q[i], exp_w[i]);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; m_ready = 1'b0;
    fifo_rd_empty = 1'b1; fifo_rd_data = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_len_guard();
    test_random();
    test_clr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout after 500000 ns");
    $fatal(1, "simulation did not complete");
  end

endmodule
